// File: rtl/cpu_debug_display.sv
// cpu_debug_display
//   Debug display controller for the single-cycle RISC-V board top.
//   Picks one probe channel, converts its low DISP_BITS bits to BCD with a
//   sequential shift-add-3 engine, scans the decimal result onto a
//   multiplexed seven-segment display, and generates the core clock-enable
//   for free-run / single-step operation.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   probe_bus  NUM_CH channels of CH_W bits, channel k at [k*CH_W +: CH_W]
//   sel        channel select (out-of-range selects channel 0)
//   freeze     hold the displayed value (blocks new conversion requests)
//   run_mode   1 = free-run, 0 = single-step
//   step_btn   asynchronous step request (level)
//   cpu_en     core clock-enable
//   an         digit anodes, active-low one-hot, bit 0 = least-significant digit
//   seg        segments {g,f,e,d,c,b,a}, active low
//   busy       conversion in progress
//
// Conversion FSM
//   state  | meaning
//   S_IDLE | waiting for a pending request
//   S_LOAD | snapshot selected channel, clear working BCD
//   S_CONV | one add-3 / shift iteration per cycle, DISP_BITS iterations
//   S_DONE | publish working BCD to the display register
module cpu_debug_display #(
  parameter int NUM_CH      = 16,
  parameter int CH_W        = 32,
  parameter int DISP_BITS   = 13,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH*CH_W-1:0] probe_bus,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   freeze,
  input  logic                   run_mode,
  input  logic                   step_btn,
  output logic                   cpu_en,
  output logic [DIGITS-1:0]      an,
  output logic [6:0]             seg,
  output logic                   busy
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(DISP_BITS);
  localparam int REF_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_DONE} state_t;

  state_t               state;
  logic                 pend;
  logic [SEL_W-1:0]     sel_q;
  logic                 sel_vld;
  logic [DISP_BITS-1:0] snap;
  logic [BCD_W-1:0]     bcd;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W-1:0]     disp;
  logic [ITER_W-1:0]    iter;

  logic [REF_W-1:0]     refresh_cnt;
  logic [IDX_W-1:0]     idx;
  logic                 refresh_wrap;
  logic                 frame_wrap;
  logic [3:0]           cur_nib;

  logic                 step_s1, step_s2, step_s3;

  logic [DISP_BITS-1:0] ch_low;
  logic                 sel_chg;
  logic                 trig;

  // Only the low DISP_BITS of each channel are ever displayed.
  logic unused_probe;
  assign unused_probe = ^probe_bus;

  // Channel mux; any select without a matching channel falls back to channel 0.
  always_comb begin
    ch_low = probe_bus[0 +: DISP_BITS];
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(sel) == k) ch_low = probe_bus[k*CH_W +: DISP_BITS];
    end
  end

  // Add 3 to every nibble that is 5 or more, ahead of the left shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] on;  // active-high {g,f,e,d,c,b,a}
    case (d)
      4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
      4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
      4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
      4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  assign refresh_wrap = (refresh_cnt == REF_W'(REFRESH_DIV - 1));
  assign frame_wrap   = refresh_wrap && (idx == IDX_W'(DIGITS - 1));

  // sel_q is not meaningful until one clock after reset; the reset-time
  // pending request already covers whatever channel is selected then.
  assign sel_chg = sel_vld && (sel != sel_q);
  assign trig    = (sel_chg || frame_wrap) && !freeze;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pend    <= 1'b1;
      sel_q   <= '0;
      sel_vld <= 1'b0;
      snap    <= '0;
      bcd     <= '0;
      disp    <= '0;
      iter    <= '0;
      busy    <= 1'b0;
    end else begin
      sel_q   <= sel;
      sel_vld <= 1'b1;
      // A new trigger wins over the IDLE consume so no request is lost.
      pend    <= trig || (pend && (state != S_IDLE));
      case (state)
        S_IDLE: if (pend) state <= S_LOAD;
        S_LOAD: begin
          snap  <= ch_low;
          bcd   <= '0;
          iter  <= '0;
          busy  <= 1'b1;
          state <= S_CONV;
        end
        S_CONV: begin
          bcd  <= {bcd_adj[BCD_W-2:0], snap[DISP_BITS-1]};
          snap <= {snap[DISP_BITS-2:0], 1'b0};
          if (iter == ITER_W'(DISP_BITS - 1)) state <= S_DONE;
          else                                  iter  <= iter + 1'b1;
        end
        S_DONE: begin
          disp  <= bcd;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cur_nib = disp[{idx, 2'b00} +: 4];

  // an and seg are both registered from the same idx so they never disagree.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      idx         <= '0;
      an          <= '1;
      seg         <= '1;
    end else begin
      an  <= ~(DIGITS'(1) << idx);
      seg <= hex7(cur_nib);
      if (refresh_wrap) begin
        refresh_cnt <= '0;
        idx         <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
      cpu_en  <= 1'b0;
    end else begin
      step_s1 <= step_btn;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
      cpu_en  <= run_mode || (step_s2 && !step_s3);
    end
  end

endmodule

// File: tb/tb_cpu_debug_display.sv
module tb_cpu_debug_display;

  localparam int NUM_CH      = 16;
  localparam int CH_W        = 32;
  localparam int DISP_BITS   = 13;
  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int SEL_W       = 5;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_CH*CH_W-1:0] probe_bus = '0;
  logic [SEL_W-1:0]       sel = '0;
  logic                   freeze = 1'b0;
  logic                   run_mode = 1'b1;
  logic                   step_btn = 1'b0;
  logic                   cpu_en;
  logic [DIGITS-1:0]      an;
  logic [6:0]             seg;
  logic                   busy;

  cpu_debug_display #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DISP_BITS(DISP_BITS), .DIGITS(DIGITS),
    .REFRESH_DIV(REFRESH_DIV), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst(rst_n), .probe_bus(probe_bus), .sel(sel), .freeze(freeze),
    .run_mode(run_mode), .step_btn(step_btn), .cpu_en(cpu_en), .an(an),
    .seg(seg), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Active-low {g,f,e,d,c,b,a} pattern of a decimal/hex digit.
  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] on;
    case (d)
      0: on = 7'h3F;  1: on = 7'h06;  2: on = 7'h5B;  3: on = 7'h4F;
      4: on = 7'h66;  5: on = 7'h6D;  6: on = 7'h7D;  7: on = 7'h07;
      8: on = 7'h7F;  9: on = 7'h6F;  10: on = 7'h77; 11: on = 7'h7C;
      12: on = 7'h39; 13: on = 7'h5E; 14: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  function automatic int digit_of(input int val, input int pos);
    int v;
    v = val;
    repeat (pos) v = v / 10;
    return v % 10;
  endfunction

  function automatic int chan_value(input logic [SEL_W-1:0] s);
    int k;
    longint v;
    k = (int'(s) < NUM_CH) ? int'(s) : 0;
    v = longint'(probe_bus[k*CH_W +: CH_W]);
    return int'(v % (longint'(1) << DISP_BITS));
  endfunction

  // Behavioural model: decimal value held as an integer, conversion tracked
  // as "cycles of busy remaining", scan as a counter/index pair.
  bit               m_pend, m_load, m_sel_vld;
  int               m_left, m_val, m_disp, m_ref, m_idx;
  logic [SEL_W-1:0] m_sel_prev;
  bit               h0, h1, h2;
  logic [3:0]       exp_an;
  logic [6:0]       exp_seg;
  logic             exp_busy, exp_cpu_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 1; m_load = 0; m_sel_vld = 0; m_left = 0; m_val = 0; m_disp = 0;
      m_ref = 0; m_idx = 0; m_sel_prev = '0; h0 = 0; h1 = 0; h2 = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_busy = 0; exp_cpu_en = 0;
    end else begin
      bit wrap, trig, was_idle;
      exp_an  = ~(4'b0001 << m_idx);
      exp_seg = seg_of(digit_of(m_disp, m_idx));
      wrap = (m_ref == REFRESH_DIV - 1) && (m_idx == DIGITS - 1);
      trig = wrap || (m_sel_vld && (sel != m_sel_prev));
      was_idle = !m_load && (m_left == 0);
      if (m_load) begin
        m_val  = chan_value(sel);
        m_left = DISP_BITS + 1;
        m_load = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) m_disp = m_val;
      end
      if (was_idle && m_pend) begin
        m_load = 1;
        m_pend = 0;
      end
      if (trig && !freeze) m_pend = 1;
      exp_busy = (m_left > 0);
      m_sel_prev = sel;
      m_sel_vld = 1;
      if (m_ref == REFRESH_DIV - 1) begin
        m_ref = 0;
        m_idx = (m_idx + 1) % DIGITS;
      end else begin
        m_ref++;
      end
      exp_cpu_en = run_mode || (h1 && !h2);
      h2 = h1; h1 = h0; h0 = step_btn;
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      chk("busy", int'(busy), int'(exp_busy));
      chk("cpu_en", int'(cpu_en), int'(exp_cpu_en));
      chk("an", int'(an), int'(exp_an));
      chk("seg", int'(seg), int'(exp_seg));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int k, input logic [CH_W-1:0] v);
    probe_bus[k*CH_W +: CH_W] = v;
  endtask

  // Decode one full scan frame from an/seg into a decimal number (-1 if unreadable).
  task automatic read_display(output int val);
    int dig [DIGITS];
    logic [3:0] pat;
    for (int d = 0; d < DIGITS; d++) dig[d] = -1;
    for (int c = 0; c < DIGITS*REFRESH_DIV + 4; c++) begin
      @(negedge clk);
      #2;
      for (int d = 0; d < DIGITS; d++) begin
        pat = ~(4'b0001 << d);
        if (an == pat) begin
          dig[d] = -1;
          for (int v = 0; v < 16; v++) if (seg == seg_of(v)) dig[d] = v;
        end
      end
    end
    val = 0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (dig[d] < 0 || dig[d] > 9) begin
        val = -1;
        break;
      end
      val = val * 10 + dig[d];
    end
  endtask

  task automatic wait_busy_rise();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin cycles(1); n++; end
    while (busy !== 1'b1 && n < 100) begin cycles(1); n++; end
    if (n >= 100) chk("busy_rise_timeout", 0, 1);
  endtask

  initial begin
    int v, cnt;
    set_ch(3, 32'h0000_1FFF);
    set_ch(5, 32'h0000_0000);
    set_ch(0, 32'd1234);
    sel = 5'd3;
    cycles(3);
    chk_en = 1'b1;
    rst_n = 1'b1;

    // First conversion after reset: busy length and 8191 on the display.
    cnt = 0;
    for (int i = 0; i < 10 && busy !== 1'b1; i++) cycles(1);
    while (busy === 1'b1 && cnt < 40) begin cycles(1); cnt++; end
    chk("busy_len", cnt, 14);
    chk("model_disp_8191", m_disp, 8191);
    cycles(20);
    read_display(v);
    chk("disp_8191", v, 8191);

    // Select change mid-conversion: current one finishes, then channel 5.
    wait_busy_rise();
    cycles(5);
    sel = 5'd5;
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin cycles(1); cnt++; end
    chk("model_first_8191", m_disp, 8191);
    cycles(60);
    read_display(v);
    chk("disp_0000", v, 0);

    // Freeze holds the value while the channel changes underneath.
    sel = 5'd3;
    cycles(60);
    read_display(v);
    chk("disp_before_freeze", v, 8191);
    freeze = 1'b1;
    cycles(50);
    set_ch(3, 32'd42);
    cycles(48);
    read_display(v);
    chk("disp_frozen", v, 8191);
    freeze = 1'b0;
    cycles(40);
    read_display(v);
    chk("disp_0042", v, 42);

    // Single-step: two long presses give two one-cycle enables.
    run_mode = 1'b0;
    cycles(3);
    cnt = 0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      step_btn = ((c < 20) || (c >= 30 && c < 50)) ? 1'b1 : 1'b0;
      #1;
      if (cpu_en === 1'b1) cnt++;
    end
    chk("step_pulses", cnt, 2);
    run_mode = 1'b1;
    cycles(2);
    #1;
    chk("run_cpu_en", int'(cpu_en), 1);
    cycles(8);

    // Reset in the middle of a conversion.
    wait_busy_rise();
    cycles(6);
    rst_n = 1'b0;
    #1;
    chk("rst_an", int'(an), 4'hF);
    chk("rst_seg", int'(seg), 7'h7F);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cpu_en", int'(cpu_en), 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(40);
    read_display(v);
    chk("disp_after_rst", v, 42);

    // Out-of-range select falls back to channel 0.
    sel = 5'd17;
    cycles(60);
    read_display(v);
    chk("disp_sel17", v, 1234);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) sel = SEL_W'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) set_ch($urandom_range(0, NUM_CH - 1), $urandom);
      if ($urandom_range(0, 49) == 0) freeze = ~freeze;
      if ($urandom_range(0, 99) == 0) run_mode = ~run_mode;
      if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
    end
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
